mux_nto1_rr: RTL and testbench

MUX_NTO1_RR -- requirements
Module: mux_nto1_rr

---
 rtl/mux_pkg.sv | 16 +
 rtl/mux_nto1_rr_if.sv | 39 +++
 rtl/rr_arbiter.sv | 32 +++
 rtl/mux_nto1_rr.sv | 76 +++++++
 tb/tb_mux_nto1_rr.sv | 212 +++++++++++++++++++++
 5 files changed

// File: rtl/mux_pkg.sv
// Shared constants and types for the round-robin N-to-1 mux.
// Optional feature macro: MUX_FORCE_SEL_EN (forced channel select).
package mux_pkg;

  localparam int unsigned DefN     = 4;
  localparam int unsigned DefWidth = 8;
  localparam int unsigned DefCw    = $clog2(DefN);

  typedef logic [DefCw-1:0] ch_idx_t;

  // Index that follows idx in a ring of n entries.
  function automatic int unsigned wrap_inc(input int unsigned idx, input int unsigned n);
    return (idx + 1) % n;
  endfunction

endpackage

// File: rtl/mux_nto1_rr_if.sv
// Handshake bundle between N producers and one consumer of mux_nto1_rr.
// MUX_FORCE_SEL_EN adds force_en/force_sel to the bundle.
interface mux_nto1_rr_if #(
  parameter int unsigned N     = mux_pkg::DefN,
  parameter int unsigned WIDTH = mux_pkg::DefWidth
);
  localparam int unsigned CW = $clog2(N);

  logic [N-1:0][WIDTH-1:0] in_data;
  logic [N-1:0]            in_valid;
  logic [N-1:0]            in_ready;
  logic [WIDTH-1:0]        out_data;
  logic [CW-1:0]           out_ch;
  logic                    out_valid;
  logic                    out_ready;
`ifdef MUX_FORCE_SEL_EN
  logic                    force_en;
  logic [CW-1:0]           force_sel;

  modport master (
    output in_data, in_valid, out_ready, force_en, force_sel,
    input  in_ready, out_data, out_ch, out_valid
  );
  modport slave (
    input  in_data, in_valid, out_ready, force_en, force_sel,
    output in_ready, out_data, out_ch, out_valid
  );
`else
  modport master (
    output in_data, in_valid, out_ready,
    input  in_ready, out_data, out_ch, out_valid
  );
  modport slave (
    input  in_data, in_valid, out_ready,
    output in_ready, out_data, out_ch, out_valid
  );
`endif

endinterface

// File: rtl/rr_arbiter.sv
// Combinational round-robin grant: first requester after ptr, wrapping.
// Unaffected by MUX_FORCE_SEL_EN; forcing is applied to req upstream.
module rr_arbiter
  import mux_pkg::*;
#(
  parameter int unsigned N = DefN
) (
  input  logic [N-1:0]         req,
  input  logic [$clog2(N)-1:0] ptr,
  output logic [N-1:0]         gnt,
  output logic [$clog2(N)-1:0] gnt_idx
);
  localparam int unsigned CW = $clog2(N);

  always_comb begin
    int unsigned idx;
    logic        found;
    gnt     = '0;
    gnt_idx = '0;
    found   = 1'b0;
    idx     = wrap_inc(int'(ptr), N);
    for (int unsigned off = 0; off < N; off++) begin
      if (!found && req[idx]) begin
        found    = 1'b1;
        gnt[idx] = 1'b1;
        gnt_idx  = CW'(idx);
      end
      idx = wrap_inc(idx, N);
    end
  end

endmodule

// File: rtl/mux_nto1_rr.sv
// N-to-1 round-robin mux with a one-word registered output slot.
// Define MUX_FORCE_SEL_EN to add force_en/force_sel channel pinning.
module mux_nto1_rr
  import mux_pkg::*;
#(
  parameter int unsigned N     = DefN,
  parameter int unsigned WIDTH = DefWidth
) (
  input logic           clk,
  input logic           rst,
  mux_nto1_rr_if.slave  bus
);
  localparam int unsigned CW = $clog2(N);

  logic [N-1:0]     req;
  logic [N-1:0]     gnt;
  logic [CW-1:0]    gnt_idx;
  logic [CW-1:0]    ptr_q;
  logic [WIDTH-1:0] data_q;
  logic [CW-1:0]    ch_q;
  logic             valid_q;
  logic             load;
  logic             ptr_upd;

`ifdef MUX_FORCE_SEL_EN
  // Shift past the top bit yields zero, so out-of-range selects grant nothing.
  always_comb begin
    req     = bus.in_valid;
    ptr_upd = 1'b1;
    if (bus.force_en) begin
      req     = bus.in_valid & (N'(1) << bus.force_sel);
      ptr_upd = 1'b0;
    end
  end
`else
  always_comb begin
    req     = bus.in_valid;
    ptr_upd = 1'b1;
  end
`endif

  rr_arbiter #(
    .N (N)
  ) u_arb (
    .req     (req),
    .ptr     (ptr_q),
    .gnt     (gnt),
    .gnt_idx (gnt_idx)
  );

  assign load         = ~valid_q | bus.out_ready;
  assign bus.in_ready = (load && !rst) ? gnt : '0;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      data_q  <= '0;
      ch_q    <= '0;
      valid_q <= 1'b0;
      ptr_q   <= CW'(N - 1);
    end else if (load) begin
      if (|gnt) begin
        data_q  <= bus.in_data[gnt_idx];
        ch_q    <= gnt_idx;
        valid_q <= 1'b1;
        if (ptr_upd) ptr_q <= gnt_idx;
      end else begin
        valid_q <= 1'b0;
      end
    end
  end

  assign bus.out_data  = data_q;
  assign bus.out_ch    = ch_q;
  assign bus.out_valid = valid_q;

endmodule

// File: tb/tb_mux_nto1_rr.sv
// Self-checking bench for mux_nto1_rr: directed scenarios plus random traffic
// compared each cycle against a behavioural round-robin model.
module tb_mux_nto1_rr;
  import mux_pkg::*;

  localparam int unsigned N     = 4;
  localparam int unsigned WIDTH = 8;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   n_chk  = 0;
  int   n_fail = 0;

  always #5 clk = ~clk;

  mux_nto1_rr_if #(.N(N), .WIDTH(WIDTH)) bus ();

  mux_nto1_rr #(
    .N     (N),
    .WIDTH (WIDTH)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus.slave)
  );

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s at %0t: got %0h expected %0h", nm, $time, act, exp);
    end
  endtask

  // Reference model: the output slot and the last-granted channel.
  int         m_ptr;
  logic       m_valid;
  logic [7:0] m_data;
  ch_idx_t    m_ch;
  int         m_g;
  logic       f_en;
  logic [1:0] f_sel;

  function automatic int pick(input logic valid, input int ptr, input logic [N-1:0] iv,
                              input logic ordy, input logic fen, input logic [1:0] fsel);
    if (valid && !ordy) return -1;
    if (fen) return (int'(fsel) < N && iv[fsel]) ? int'(fsel) : -1;
    for (int off = 1; off <= N; off++) begin
      if (iv[(ptr + off) % N]) return (ptr + off) % N;
    end
    return -1;
  endfunction

`ifdef MUX_FORCE_SEL_EN
  assign f_en  = bus.force_en;
  assign f_sel = bus.force_sel;
`else
  assign f_en  = 1'b0;
  assign f_sel = 2'd0;
`endif

  assign m_g = pick(m_valid, m_ptr, bus.in_valid, bus.out_ready, f_en, f_sel);

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      m_valid <= 1'b0;
      m_data  <= '0;
      m_ch    <= '0;
      m_ptr   <= N - 1;
    end else if (m_g >= 0) begin
      m_valid <= 1'b1;
      m_data  <= bus.in_data[m_g];
      m_ch    <= ch_idx_t'(m_g);
      if (!f_en) m_ptr <= m_g;
    end else if (!m_valid || bus.out_ready) begin
      m_valid <= 1'b0;
    end
  end

  always @(negedge clk) begin
    logic [N-1:0] exp_rdy;
    if (!rst) begin
      exp_rdy = (m_g >= 0) ? 4'(1 << m_g) : 4'b0000;
      chk("model_in_ready", 64'(bus.in_ready), 64'(exp_rdy));
      chk("model_out_valid", 64'(bus.out_valid), 64'(m_valid));
      if (m_valid) begin
        chk("model_out_data", 64'(bus.out_data), 64'(m_data));
        chk("model_out_ch", 64'(bus.out_ch), 64'(m_ch));
      end
    end
  end

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  initial begin
    bus.in_valid  = '0;
    bus.in_data   = '0;
    bus.out_ready = 1'b1;
`ifdef MUX_FORCE_SEL_EN
    bus.force_en  = 1'b0;
    bus.force_sel = '0;
`endif
    cyc();
    cyc();
    bus.in_valid = 4'b1111;
    for (int i = 0; i < N; i++) bus.in_data[i] = 8'(8'hA0 + i);
    #1;
    chk("reset_out_valid", 64'(bus.out_valid), 64'd0);
    chk("reset_out_data", 64'(bus.out_data), 64'd0);
    chk("reset_out_ch", 64'(bus.out_ch), 64'd0);
    chk("reset_in_ready", 64'(bus.in_ready), 64'd0);
    cyc();
    rst = 1'b0;

    // Fairness: all channels requesting.
    for (int k = 0; k < 5; k++) begin
      cyc();
      chk("fair_out_ch", 64'(bus.out_ch), 64'(k % 4));
      chk("fair_out_data", 64'(bus.out_data), 64'(8'hA0 + k % 4));
    end

    // Stall with 0xA2 held.
    bus.in_valid = 4'b0100;
    cyc();
    bus.out_ready = 1'b0;
    bus.in_valid  = 4'b1111;
    for (int k = 0; k < 3; k++) begin
      cyc();
      chk("stall_out_data", 64'(bus.out_data), 64'hA2);
      chk("stall_out_valid", 64'(bus.out_valid), 64'd1);
      chk("stall_in_ready", 64'(bus.in_ready), 64'd0);
    end

    // Wrap-around from ptr=3.
    bus.out_ready = 1'b1;
    bus.in_valid  = 4'b1000;
    cyc();
    chk("wrap_setup_ch", 64'(bus.out_ch), 64'd3);
    bus.in_valid = 4'b0010;
    #1;
    chk("wrap_in_ready", 64'(bus.in_ready), 64'b0010);
    cyc();
    chk("wrap_out_ch1", 64'(bus.out_ch), 64'd1);
    bus.in_valid = 4'b1001;
    cyc();
    chk("wrap_out_ch3", 64'(bus.out_ch), 64'd3);

    // Single-channel streaming, no bubbles, then drain.
    bus.in_valid = 4'b0100;
    for (int k = 0; k < 5; k++) begin
      bus.in_data[2] = 8'(8'hB0 + k);
      cyc();
      chk("stream_out_valid", 64'(bus.out_valid), 64'd1);
      chk("stream_out_data", 64'(bus.out_data), 64'(8'hB0 + k));
    end
    bus.in_valid = 4'b0000;
    cyc();
    chk("stream_drain_valid", 64'(bus.out_valid), 64'd0);

    // Asynchronous reset with a word held.
    bus.in_valid  = 4'b1111;
    bus.out_ready = 1'b0;
    cyc();
    chk("areset_pre_valid", 64'(bus.out_valid), 64'd1);
    #2;
    rst = 1'b1;
    #1;
    chk("areset_out_valid", 64'(bus.out_valid), 64'd0);
    chk("areset_out_data", 64'(bus.out_data), 64'd0);
    chk("areset_out_ch", 64'(bus.out_ch), 64'd0);
    chk("areset_in_ready", 64'(bus.in_ready), 64'd0);
    cyc();
    rst = 1'b0;
    bus.out_ready = 1'b1;
    cyc();
    chk("areset_first_ch", 64'(bus.out_ch), 64'd0);

    // Random traffic against the model.
    repeat (400) begin
      bus.in_valid  = 4'($urandom);
      for (int i = 0; i < N; i++) bus.in_data[i] = 8'($urandom);
      bus.out_ready = ($urandom_range(0, 3) != 0);
      cyc();
    end

`ifdef MUX_FORCE_SEL_EN
    bus.force_en  = 1'b1;
    bus.force_sel = 2'd2;
    bus.in_valid  = 4'b1111;
    bus.out_ready = 1'b1;
    for (int k = 0; k < 4; k++) begin
      #1;
      chk("force_in_ready", 64'(bus.in_ready), 64'b0100);
      cyc();
      chk("force_out_ch", 64'(bus.out_ch), 64'd2);
    end
    bus.force_en = 1'b0;
    repeat (50) begin
      bus.in_valid  = 4'($urandom);
      bus.out_ready = ($urandom_range(0, 1) != 0);
      cyc();
    end
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
